// File: rtl/mandelbrot_lane_scheduler.sv
// Round-robin scheduler that shares one combinational mandelbrot ALU across LANES pixel contexts.
// Pixels are issued in raster order and results leave tagged with x/y over a valid/ready stream.
module mandelbrot_lane_scheduler #(
  parameter int BITWIDTH  = 10,
  parameter int CTRWIDTH  = 7,
  parameter int LANES     = 4,
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int CR_OFFSET = -560,
  parameter int CI_OFFSET = -320,
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_run,
  input  logic [CTRWIDTH-1:0] i_max_ctr,
  output logic [BITWIDTH-1:0] o_alu_cr,
  output logic [BITWIDTH-1:0] o_alu_ci,
  output logic [BITWIDTH-1:0] o_alu_zr,
  output logic [BITWIDTH-1:0] o_alu_zi,
  input  logic [BITWIDTH-1:0] i_alu_out_zr,
  input  logic [BITWIDTH-1:0] i_alu_out_zi,
  input  logic                i_alu_size,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic [XW-1:0]       o_res_x,
  output logic [YW-1:0]       o_res_y,
  output logic [CTRWIDTH-1:0] o_res_ctr,
  output logic                o_busy,
  output logic                o_done
);

  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BITWIDTH-1:0] CR_BASE = BITWIDTH'(CR_OFFSET);
  localparam logic [BITWIDTH-1:0] CI_BASE = BITWIDTH'(CI_OFFSET);
  localparam logic [XW-1:0]       X_LAST  = XW'(WIDTH - 1);
  localparam logic [YW-1:0]       Y_LAST  = YW'(HEIGHT - 1);
  localparam logic [PW-1:0]       P_LAST  = PW'(LANES - 1);

  typedef enum logic {S_IDLE, S_RUN} ctrl_state_t;
  typedef enum logic [1:0] {L_IDLE, L_ITER, L_DONE} lane_state_t;

  ctrl_state_t r_state, w_state_next;
  logic        r_done;
  logic [PW-1:0] r_p;
  logic [XW-1:0] r_gen_x;
  logic [YW-1:0] r_gen_y;
  logic          r_gen_end;

  lane_state_t         r_lst [LANES];
  logic [BITWIDTH-1:0] r_cr  [LANES];
  logic [BITWIDTH-1:0] r_ci  [LANES];
  logic [BITWIDTH-1:0] r_zr  [LANES];
  logic [BITWIDTH-1:0] r_zi  [LANES];
  logic [CTRWIDTH-1:0] r_ctr [LANES];
  logic [XW-1:0]       r_lx  [LANES];
  logic [YW-1:0]       r_ly  [LANES];

  logic                r_res_valid;
  logic [XW-1:0]       r_res_x;
  logic [YW-1:0]       r_res_y;
  logic [CTRWIDTH-1:0] r_res_ctr;

  logic w_busy, w_start, w_frame_end, w_all_idle, w_accept, w_slot_free;
  logic w_gen_adv, w_load_res;
  lane_state_t         w_lst_next;
  logic [BITWIDTH-1:0] w_cr_next, w_ci_next, w_zr_next, w_zi_next;
  logic [CTRWIDTH-1:0] w_ctr_next;
  logic [XW-1:0]       w_lx_next;
  logic [YW-1:0]       w_ly_next;

  assign w_busy      = (r_state == S_RUN);
  assign w_accept    = r_res_valid & i_res_ready;
  assign w_slot_free = ~r_res_valid | w_accept;

  assign o_alu_cr    = r_cr[r_p];
  assign o_alu_ci    = r_ci[r_p];
  assign o_alu_zr    = r_zr[r_p];
  assign o_alu_zi    = r_zi[r_p];
  assign o_res_valid = r_res_valid;
  assign o_res_x     = r_res_x;
  assign o_res_y     = r_res_y;
  assign o_res_ctr   = r_res_ctr;
  assign o_busy      = w_busy;
  assign o_done      = r_done;

  always_comb begin
    w_all_idle = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (r_lst[i] != L_IDLE) w_all_idle = 1'b0;
    end
  end

  // Frame ends once nothing is queued anywhere: generator, lanes and result register all drained.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run) begin
          w_start      = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (r_gen_end && w_all_idle && w_slot_free) begin
          w_frame_end  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_lst_next = r_lst[r_p];
    w_cr_next  = r_cr[r_p];
    w_ci_next  = r_ci[r_p];
    w_zr_next  = r_zr[r_p];
    w_zi_next  = r_zi[r_p];
    w_ctr_next = r_ctr[r_p];
    w_lx_next  = r_lx[r_p];
    w_ly_next  = r_ly[r_p];
    w_gen_adv  = 1'b0;
    w_load_res = 1'b0;
    if (w_busy) begin
      case (r_lst[r_p])
        L_IDLE: begin
          if (!r_gen_end) begin
            w_lst_next = L_ITER;
            w_cr_next  = CR_BASE + BITWIDTH'(r_gen_x);
            w_ci_next  = CI_BASE + BITWIDTH'(r_gen_y);
            w_zr_next  = '0;
            w_zi_next  = '0;
            w_ctr_next = '0;
            w_lx_next  = r_gen_x;
            w_ly_next  = r_gen_y;
            w_gen_adv  = 1'b1;
          end
        end
        L_ITER: begin
          // >= rather than == keeps ctr bounded even if max_ctr is lowered mid-frame.
          if (i_alu_size || (r_ctr[r_p] >= i_max_ctr)) begin
            w_lst_next = L_DONE;
          end else begin
            w_zr_next  = i_alu_out_zr;
            w_zi_next  = i_alu_out_zi;
            w_ctr_next = r_ctr[r_p] + CTRWIDTH'(1);
          end
        end
        L_DONE: begin
          if (w_slot_free) begin
            w_load_res = 1'b1;
            w_lst_next = L_IDLE;
          end
        end
        default: w_lst_next = L_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_done    <= 1'b0;
      r_p       <= '0;
      r_gen_x   <= '0;
      r_gen_y   <= '0;
      r_gen_end <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_frame_end;
      if (w_start || w_frame_end) begin
        r_p <= '0;
      end else if (w_busy) begin
        r_p <= (r_p == P_LAST) ? '0 : r_p + PW'(1);
      end
      if (w_start) begin
        r_gen_x   <= '0;
        r_gen_y   <= '0;
        r_gen_end <= 1'b0;
      end else if (w_gen_adv) begin
        if (r_gen_x == X_LAST) begin
          r_gen_x <= '0;
          if (r_gen_y == Y_LAST) r_gen_end <= 1'b1;
          else                   r_gen_y   <= r_gen_y + YW'(1);
        end else begin
          r_gen_x <= r_gen_x + XW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < LANES; i++) begin
        r_lst[i] <= L_IDLE;
        r_cr[i]  <= '0;
        r_ci[i]  <= '0;
        r_zr[i]  <= '0;
        r_zi[i]  <= '0;
        r_ctr[i] <= '0;
        r_lx[i]  <= '0;
        r_ly[i]  <= '0;
      end
    end else if (w_busy) begin
      r_lst[r_p] <= w_lst_next;
      r_cr[r_p]  <= w_cr_next;
      r_ci[r_p]  <= w_ci_next;
      r_zr[r_p]  <= w_zr_next;
      r_zi[r_p]  <= w_zi_next;
      r_ctr[r_p] <= w_ctr_next;
      r_lx[r_p]  <= w_lx_next;
      r_ly[r_p]  <= w_ly_next;
    end
  end

  // A DONE lane may refill the result register in the same cycle the old result is accepted.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_res_valid <= 1'b0;
      r_res_x     <= '0;
      r_res_y     <= '0;
      r_res_ctr   <= '0;
    end else if (w_load_res) begin
      r_res_valid <= 1'b1;
      r_res_x     <= r_lx[r_p];
      r_res_y     <= r_ly[r_p];
      r_res_ctr   <= r_ctr[r_p];
    end else if (w_accept) begin
      r_res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mandelbrot_lane_scheduler.sv
// Self-checking bench: stub ALU with per-pixel escape rules, frame scoreboard and corner-case sequences.
module tb_mandelbrot_lane_scheduler;

  localparam int BW = 10;
  localparam int CW = 7;
  localparam int LN = 4;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int CR_OFF = -560;
  localparam int CI_OFF = -320;
  localparam logic [BW-1:0] CR_B = BW'(CR_OFF);
  localparam logic [BW-1:0] CI_B = BW'(CI_OFF);

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [CW-1:0] max_ctr;
  logic [BW-1:0] alu_cr, alu_ci, alu_zr, alu_zi;
  logic [BW-1:0] out_zr, out_zi;
  logic          alu_size;
  logic          res_valid, res_ready;
  logic [1:0]    res_x;
  logic [0:0]    res_y;
  logic [CW-1:0] res_ctr;
  logic          busy, done;

  always #5 clk = ~clk;

  mandelbrot_lane_scheduler #(
    .BITWIDTH(BW), .CTRWIDTH(CW), .LANES(LN), .WIDTH(W), .HEIGHT(H),
    .CR_OFFSET(CR_OFF), .CI_OFFSET(CI_OFF)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_run(run), .i_max_ctr(max_ctr),
    .o_alu_cr(alu_cr), .o_alu_ci(alu_ci), .o_alu_zr(alu_zr), .o_alu_zi(alu_zi),
    .i_alu_out_zr(out_zr), .i_alu_out_zi(out_zi), .i_alu_size(alu_size),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_x(res_x), .o_res_y(res_y), .o_res_ctr(res_ctr),
    .o_busy(busy), .o_done(done)
  );

  // Stub ALU: z grows by a fixed step; escape rule chosen by stub_mode, keyed on the decoded pixel.
  int            stub_mode;
  int            k_tab [W*H];
  logic [BW-1:0] dx, dy;
  logic          in_rng;
  int            pix;

  always_comb begin
    dx       = alu_cr - CR_B;
    dy       = alu_ci - CI_B;
    in_rng   = (dx < BW'(W)) && (dy < BW'(H));
    pix      = in_rng ? (int'(dy) * W + int'(dx)) : 0;
    out_zr   = alu_zr + BW'(1);
    out_zi   = alu_zi + BW'(3);
    alu_size = 1'b0;
    case (stub_mode)
      0:       alu_size = 1'b1;
      1:       alu_size = 1'b0;
      2:       alu_size = in_rng && (dx == BW'(2)) && (dy == BW'(0));
      3:       alu_size = in_rng && (int'(alu_zr) >= k_tab[pix]);
      default: alu_size = 1'b0;
    endcase
  end

  typedef struct {int x; int y; int ctr;} res_t;
  res_t res_q[$];
  int   done_cnt;
  int   last_zr [W*H];

  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready) begin
        res_q.push_back('{int'(res_x), int'(res_y), int'(res_ctr)});
        $display("result x=%0d y=%0d ctr=%0d", res_x, res_y, res_ctr);
      end
      if (done) done_cnt++;
      if (busy && in_rng) last_zr[pix] = int'(alu_zr);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference rule: iteration stops at the first escape or at max_ctr, whichever comes first.
  function automatic int exp_ctr(input int mode, input int maxc, input int x, input int y);
    int k;
    case (mode)
      0:       return 0;
      1:       return maxc;
      2:       return (x == 2 && y == 0) ? 0 : maxc;
      default: begin
        k = k_tab[y*W + x];
        return (k < maxc) ? k : maxc;
      end
    endcase
  endfunction

  task automatic start_frame();
    res_q.delete();
    done_cnt  = 0;
    res_ready = 1'b1;
    foreach (last_zr[j]) last_zr[j] = -1;
    @(posedge clk); #1 run = 1'b1;
    @(posedge clk); #1 run = 1'b0;
  endtask

  task automatic finish_frame(input int mode, input int maxc, input int rdy, input int order, input int exp_n);
    int   t;
    int   p;
    int   i00, i10, i20;
    int   seen [W*H];
    res_t r;
    t = 0;
    while (done_cnt == 0 && t < 4000) begin
      @(posedge clk); #1;
      res_ready = (rdy == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      t++;
    end
    chk("frame_done_seen", (done_cnt > 0) ? 1 : 0, 1);
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_after_frame", int'(busy), 0);
    chk("done_pulse_cycles", done_cnt, 1);
    chk("result_count", res_q.size(), exp_n);
    foreach (seen[j]) seen[j] = 0;
    i00 = -1; i10 = -1; i20 = -1;
    for (int i = 0; i < res_q.size(); i++) begin
      r = res_q[i];
      p = r.y * W + r.x;
      seen[p]++;
      chk("res_ctr", r.ctr, exp_ctr(mode, maxc, r.x, r.y));
      chk("z_update_count", last_zr[p], exp_ctr(mode, maxc, r.x, r.y));
      if (order == 1) chk("raster_order", p, i);
      if (p == 0) i00 = i;
      if (p == 1) i10 = i;
      if (p == 2) i20 = i;
    end
    foreach (seen[j]) chk("pixel_once", seen[j], 1);
    if (order == 2) chk("early_escape_first", (i20 >= 0 && i20 < i00 && i20 < i10) ? 1 : 0, 1);
  endtask

  typedef struct {int mode; int maxc; int rdy; int order; int opchk; int exp_n;} vec_t;
  vec_t tbl [7];

  initial begin
    int            t;
    int            bad;
    int            mc;
    logic [1:0]    cx;
    logic [0:0]    cy;
    logic [CW-1:0] cc;
    logic [BW-1:0] e_cr;

    rst = 1'b1; run = 1'b0; res_ready = 1'b1; max_ctr = '0; stub_mode = 0;
    done_cnt = 0;
    foreach (k_tab[j]) k_tab[j] = 0;
    foreach (last_zr[j]) last_zr[j] = -1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_res_valid", int'(res_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_res_x", int'(res_x), 0);
    chk("reset_res_y", int'(res_y), 0);
    chk("reset_res_ctr", int'(res_ctr), 0);

    tbl[0] = '{0,   7, 0, 1, 0, 8};
    tbl[1] = '{1,   5, 0, 0, 1, 8};
    tbl[2] = '{2,   3, 0, 2, 0, 8};
    tbl[3] = '{1,   0, 0, 0, 0, 8};
    tbl[4] = '{3,  -1, 1, 0, 0, 8};
    tbl[5] = '{3, 127, 1, 0, 0, 8};
    tbl[6] = '{1, 127, 1, 0, 0, 8};

    for (int v = 0; v < 7; v++) begin
      mc = (tbl[v].maxc < 0) ? int'($urandom_range(0, 10)) : tbl[v].maxc;
      foreach (k_tab[j]) k_tab[j] = int'($urandom_range(0, 9));
      stub_mode = tbl[v].mode;
      max_ctr   = CW'(mc);
      start_frame();
      if (tbl[v].opchk == 1) begin
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < LN; i++) begin
          e_cr = CR_B + BW'(i);
          chk("alu_cr_first_iter", int'(alu_cr), int'(e_cr));
          chk("alu_ci_first_iter", int'(alu_ci), int'(CI_B));
          chk("alu_zr_first_iter", int'(alu_zr), 0);
          @(posedge clk); #1;
        end
      end
      finish_frame(tbl[v].mode, mc, tbl[v].rdy, tbl[v].order, tbl[v].exp_n);
    end

    // Backpressure: hold ready low for 50 cycles mid-frame.
    stub_mode = 1; max_ctr = CW'(2);
    start_frame();
    t = 0;
    while (res_q.size() < 1 && t < 300) begin @(posedge clk); #1; t++; end
    chk("first_result_seen", (res_q.size() >= 1) ? 1 : 0, 1);
    res_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_valid", int'(res_valid), 1);
    cx = res_x; cy = res_y; cc = res_ctr;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (!res_valid || !busy || res_x != cx || res_y != cy || res_ctr != cc) bad++;
    end
    chk("stall_payload_stable", bad, 0);
    finish_frame(1, 2, 0, 0, 8);

    // Asynchronous reset between edges while a result is pending.
    stub_mode = 1; max_ctr = CW'(3);
    start_frame();
    t = 0;
    while (res_q.size() < 1 && t < 300) begin @(posedge clk); #1; t++; end
    res_ready = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("pre_reset_valid", int'(res_valid), 1);
    #3 rst = 1'b1;
    #1;
    chk("abort_res_valid", int'(res_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    done_cnt = 0;
    @(posedge clk);
    #4 rst = 1'b0;
    res_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt, 0);
    chk("idle_after_abort", int'(busy), 0);
    stub_mode = 0; max_ctr = CW'(3);
    start_frame();
    finish_frame(0, 3, 0, 1, 8);

    // Run pulses while busy must be ignored.
    stub_mode = 0; max_ctr = CW'(4);
    start_frame();
    repeat (3) begin
      @(posedge clk); #1 run = 1'b1;
      @(posedge clk); #1 run = 1'b0;
    end
    finish_frame(0, 4, 0, 0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mandelbrot_lane_scheduler.md
Name: mandelbrot_lane_scheduler

Overview:
- Time-multiplexes one combinational mandelbrot_alu across LANES independent pixel contexts, so every ALU slot does useful work.
- Generates pixel coordinates in raster order, runs the escape iteration per lane and emits tagged results over a valid/ready stream.
- Sits between the frame start control and the colour/VGA output path.
- Replaces the single-context iteration FSM in the top level.

Parameters:
- BITWIDTH, 10, width of cr/ci/zr/zi (signed).
- CTRWIDTH, 7, iteration counter width.
- LANES, 4, number of pixel contexts (1..8).
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- CR_OFFSET, -560, cr of pixel x=0.
- CI_OFFSET, -320, ci of line y=0.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  frame start request; sampled only when idle.
- max_ctr  in  CTRWIDTH  iteration limit.
- alu_cr, alu_ci, alu_zr, alu_zi  out  BITWIDTH each  operands for the current slot lane.
- alu_out_zr, alu_out_zi  in  BITWIDTH each  next z from the ALU.
- alu_size  in  1  escape flag from the ALU.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_x  out  clog2(WIDTH)  pixel x.
- res_y  out  clog2(HEIGHT)  pixel y.
- res_ctr  out  CTRWIDTH  final iteration count.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset, asynchronous: all lanes IDLE, slot pointer p=0, generator at (0,0), result register empty. Outputs res_valid=0, busy=0, done=0; res_x/res_y/res_ctr=0.
- Idle (busy=0): run=1 sets busy=1 next cycle and rewinds the generator to (0,0). run while busy is ignored.
- Slot pointer p advances 0..LANES-1 and wraps to 0 every cycle while busy. Only lane p acts in a cycle.
- ALU operands are driven from lane p's registers (combinational mux). Lanes not in ITER drive their register values; the ALU outputs are then ignored.
- Lane state IDLE:
  - If the generator is not exhausted: load cr=CR_OFFSET+x, ci=CI_OFFSET+y, zr=zi=0, ctr=0, tags x,y; advance the generator; go to ITER.
  - Generator advance: x+1; at x=WIDTH-1, x=0 and y+1; after (WIDTH-1, HEIGHT-1) the generator is exhausted.
- Lane state ITER:
  - If alu_size=1 or ctr==max_ctr: go to DONE; z and ctr are held.
  - Else: zr<=alu_out_zr, zi<=alu_out_zi, ctr<=ctr+1.
  - max_ctr=0 gives ctr=0 with no iteration.
- Lane state DONE: if the result register is empty, or res_valid&&res_ready this cycle, copy {x,y,ctr} into it (res_valid=1) and go to IDLE. Otherwise stay in DONE; no loss, no overwrite.
- The IDLE lane reloads on its next visit, one LANES period later.
- Result register: res_valid holds until res_ready. Payload is stable while res_valid&&!res_ready. Accept plus new load in the same cycle gives back-to-back valid.
- Results may leave out of raster order. The x/y tags identify the pixel. Every pixel is emitted exactly once per frame.
- Frame end: all of the following hold → done=1 for exactly one cycle, busy=0 the same cycle, p=0.
  - generator exhausted;
  - all lanes IDLE;
  - result register empty, or accepted this cycle.
- A new run is accepted from the next cycle.
- Arithmetic: cr/ci offsets are added at BITWIDTH, signed, wrapping. ctr never exceeds max_ctr.
- Reset mid-frame: immediate abort. No done pulse. A pending result is discarded.

Test Plan:
- Bench parameters for all scenarios: WIDTH=4, HEIGHT=2, LANES=4. Stub ALU with alu_size=1, res_ready=1, one run pulse → 8 results, all res_ctr=0, tags (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1) in that order; one done pulse; busy low afterwards.
- Stub ALU with alu_size=0, max_ctr=5 → every res_ctr=5. The stub sees each lane's z sequence update exactly 5 times. alu_cr at pixel (x,y) equals CR_OFFSET+x.
- res_ready=0 for 50 cycles mid-frame → res_valid stays 1 with a stable payload; lanes stall in DONE. Release → all 8 distinct tags still delivered, no duplicates.
- Stub alu_size=1 only for lane 2's pixel → that result has ctr=0 and the other pixels have ctr=max_ctr=3. The (2,0) result precedes the earlier-started pixels' results, with correct tags.
- Assert reset for 1 cycle mid-frame (asynchronous, between clock edges) → res_valid, busy, done drop immediately. No done pulse. A following run produces a full 8-result frame.
- run pulsed again while busy → ignored; exactly 8 results and one done. max_ctr=0 → all res_ctr=0.
